// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: one 48-bit subkey per valid/ready handshake, K1..K16 or K16..K1.
// Latency 1 cycle start-to-first-subkey; subkey, index and C/D state hold while ready is low.
module des_key_sched_seq #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    output logic        busy_o,
    output logic [47:0] subkey_o,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic [3:0]  subkey_idx_o,
    output logic        subkey_last_o,
    output logic        parity_err_o
);

    // Tables hold 1-based DES bit numbers; DES bit 1 is the MSB of the source vector.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one; all others by two.
    function automatic logic shift_two(input logic [3:0] i);
        return !(i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15);
    endfunction

    // Left rotation moves bits toward DES bit 1, which sits at the MSB.
    function automatic logic [27:0] rol28(input logic [27:0] h, input logic two);
        return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] h, input logic two);
        return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

    state_t      state_q;
    logic [55:0] cd_q;
    logic [3:0]  count_q;
    logic [3:0]  idx_q;
    logic        mode_q;
    logic        valid_q;
    logic        busy_q;
    logic        perr_q;

    logic [55:0] load_cd_d;
    logic [55:0] step_cd_d;
    logic [3:0]  step_idx_d;
    logic        parity_bad_d;

    always_comb begin
        logic [55:0] c0d0;
        logic        two;
        c0d0 = pc1(key_i);
        load_cd_d = decrypt_i ? c0d0
                              : {rol28(c0d0[55:28], 1'b0), rol28(c0d0[27:0], 1'b0)};
        if (mode_q) begin
            // Undo the shift of the key just emitted to reach the previous round's C/D.
            two        = shift_two(idx_q);
            step_cd_d  = {ror28(cd_q[55:28], two), ror28(cd_q[27:0], two)};
            step_idx_d = idx_q - 4'd1;
        end else begin
            two        = shift_two(idx_q + 4'd1);
            step_cd_d  = {rol28(cd_q[55:28], two), rol28(cd_q[27:0], two)};
            step_idx_d = idx_q + 4'd1;
        end
    end

    always_comb begin
        parity_bad_d = 1'b0;
        for (int b = 0; b < 8; b++) parity_bad_d = parity_bad_d | ~(^key_i[8*b +: 8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cd_q    <= '0;
            count_q <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cd_q    <= load_cd_d;
                        mode_q  <= decrypt_i;
                        idx_q   <= decrypt_i ? 4'd15 : 4'd0;
                        count_q <= 4'd0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        perr_q  <= PARITY_CHECK && parity_bad_d;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (valid_q && subkey_ready_i) begin
                        if (count_q == 4'd15) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            count_q <= count_q + 4'd1;
                            cd_q    <= step_cd_d;
                            idx_q   <= step_idx_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign subkey_o       = pc2(cd_q);
    assign subkey_valid_o = valid_q;
    assign subkey_idx_o   = idx_q;
    assign subkey_last_o  = valid_q && (count_q == 4'd15);
    assign parity_err_o   = PARITY_CHECK ? perr_q : 1'b0;

endmodule
